// File: rtl/adam_mem_pkg.sv
// Shared types and constants for the ADAM AXI-Lite memory responder.
// ADAM_MEM_ZERO_INIT_EN adds the INIT state used by the post-reset zero sweep.
package adam_mem_pkg;

    typedef enum logic [2:0] {
        ST_PAUSED = 3'd1,
        ST_IDLE   = 3'd2,
        ST_BRESP  = 3'd3,
        ST_RDATA  = 3'd4
`ifdef ADAM_MEM_ZERO_INIT_EN
        ,
        ST_INIT   = 3'd0
`endif
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_for(input logic in_range);
        if (in_range) begin
            return RESP_OKAY;
        end else begin
            return RESP_SLVERR;
        end
    endfunction

endpackage

// File: rtl/adam_mem_sram.sv
// Single-port byte-enabled word array with a registered read port (one-cycle latency).
// Kept as its own module so a technology macro can replace it.
module adam_mem_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-lane writes; the array itself is never reset
    always_ff @(posedge clk) begin
        if (req && we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data register, updated only by a read access so it holds otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (req && !we) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/adam_mem_axil.sv
// AXI-Lite memory responder with pause handshake, one transaction at a time.
// Optional ADAM_MEM_ZERO_INIT_EN: zero the whole array after every reset before pausing.
module adam_mem_axil
    import adam_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pause_req,
    output logic                    pause_ack,
    input  logic [ADDR_WIDTH-1:0]   axil_awaddr,
    input  logic [2:0]              axil_awprot,
    input  logic                    axil_awvalid,
    output logic                    axil_awready,
    input  logic [DATA_WIDTH-1:0]   axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] axil_wstrb,
    input  logic                    axil_wvalid,
    output logic                    axil_wready,
    output logic [1:0]              axil_bresp,
    output logic                    axil_bvalid,
    input  logic                    axil_bready,
    input  logic [ADDR_WIDTH-1:0]   axil_araddr,
    input  logic [2:0]              axil_arprot,
    input  logic                    axil_arvalid,
    output logic                    axil_arready,
    output logic [DATA_WIDTH-1:0]   axil_rdata,
    output logic [1:0]              axil_rresp,
    output logic                    axil_rvalid,
    input  logic                    axil_rready
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int IDX_HI   = $clog2(SIZE);
    localparam int DEPTH    = SIZE / BYTES;
    localparam int IDX_BITS = IDX_HI - OFF_BITS;

    state_e                state_r, state_s;
    logic                  prefer_read_r;
    logic                  ack_r, bvalid_r, rvalid_r;
    logic [1:0]            bresp_r, rresp_r;
    logic                  wr_ready_s, rd_ready_s;
    logic                  wr_acc_s, rd_acc_s;
    logic                  wr_in_range_s, rd_in_range_s;
    logic                  mem_req_s, mem_we_s;
    logic [BYTES-1:0]      mem_be_s;
    logic [IDX_BITS-1:0]   mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;
    logic                  unused_s;

    assign unused_s      = ^{axil_awprot, axil_arprot};
    assign wr_ready_s    = axil_awvalid && axil_wvalid;
    assign rd_ready_s    = axil_arvalid;
    assign wr_in_range_s = (axil_awaddr < ADDR_WIDTH'(SIZE));
    assign rd_in_range_s = (axil_araddr < ADDR_WIDTH'(SIZE));

`ifdef ADAM_MEM_ZERO_INIT_EN
    logic [IDX_BITS-1:0] init_cnt_r;
    logic                init_last_s;

    assign init_last_s = (init_cnt_r == IDX_BITS'(DEPTH - 1));

    // Sweep counter; restarts from word 0 on every reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt_r <= '0;
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + IDX_BITS'(1);
        end else begin
            init_cnt_r <= '0;
        end
    end
`endif

    // Next state and accept strobes; pause wins over pending requests in IDLE
    always_comb begin
        state_s  = state_r;
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        case (state_r)
`ifdef ADAM_MEM_ZERO_INIT_EN
            ST_INIT: begin
                if (init_last_s) begin
                    state_s = ST_PAUSED;
                end else begin
                    state_s = ST_INIT;
                end
            end
`endif
            ST_PAUSED: begin
                if (!pause_req) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_IDLE: begin
                if (pause_req) begin
                    state_s = ST_PAUSED;
                end else if (wr_ready_s && (!rd_ready_s || !prefer_read_r)) begin
                    wr_acc_s = 1'b1;
                    state_s  = ST_BRESP;
                end else if (rd_ready_s) begin
                    rd_acc_s = 1'b1;
                    state_s  = ST_RDATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BRESP: begin
                if (axil_bready) begin
                    state_s = pause_req ? ST_PAUSED : ST_IDLE;
                end else begin
                    state_s = ST_BRESP;
                end
            end
            ST_RDATA: begin
                if (axil_rready) begin
                    state_s = pause_req ? ST_PAUSED : ST_IDLE;
                end else begin
                    state_s = ST_RDATA;
                end
            end
            default: begin
                state_s = ST_PAUSED;
            end
        endcase
    end

    // Array port steering; out-of-range accesses never touch the array
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_be_s    = '0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
`ifdef ADAM_MEM_ZERO_INIT_EN
        if (state_r == ST_INIT) begin
            mem_req_s  = 1'b1;
            mem_we_s   = 1'b1;
            mem_be_s   = '1;
            mem_addr_s = init_cnt_r;
        end else
`endif
        if (wr_acc_s) begin
            mem_req_s   = wr_in_range_s;
            mem_we_s    = 1'b1;
            mem_be_s    = axil_wstrb;
            mem_addr_s  = axil_awaddr[IDX_HI-1:OFF_BITS];
            mem_wdata_s = axil_wdata;
        end else if (rd_acc_s) begin
            mem_req_s  = rd_in_range_s;
            mem_addr_s = axil_araddr[IDX_HI-1:OFF_BITS];
        end else begin
            mem_req_s = 1'b0;
        end
    end

    // State, handshake outputs (loaded from next state) and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef ADAM_MEM_ZERO_INIT_EN
            state_r <= ST_INIT;
`else
            state_r <= ST_PAUSED;
`endif
            ack_r         <= 1'b1;
            bvalid_r      <= 1'b0;
            rvalid_r      <= 1'b0;
            bresp_r       <= RESP_OKAY;
            rresp_r       <= RESP_OKAY;
            prefer_read_r <= 1'b0;
        end else begin
            state_r  <= state_s;
`ifdef ADAM_MEM_ZERO_INIT_EN
            ack_r    <= (state_s == ST_PAUSED) || (state_s == ST_INIT);
`else
            ack_r    <= (state_s == ST_PAUSED);
`endif
            bvalid_r <= (state_s == ST_BRESP);
            rvalid_r <= (state_s == ST_RDATA);
            if (wr_acc_s) begin
                bresp_r       <= resp_for(wr_in_range_s);
                prefer_read_r <= 1'b1;
            end else if (rd_acc_s) begin
                rresp_r       <= resp_for(rd_in_range_s);
                prefer_read_r <= 1'b0;
            end else begin
                prefer_read_r <= prefer_read_r;
            end
        end
    end

    adam_mem_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_BITS  (IDX_BITS)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (mem_req_s),
        .we    (mem_we_s),
        .be    (mem_be_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    assign pause_ack    = ack_r;
    assign axil_awready = wr_acc_s;
    assign axil_wready  = wr_acc_s;
    assign axil_arready = rd_acc_s;
    assign axil_bvalid  = bvalid_r;
    assign axil_bresp   = bresp_r;
    assign axil_rvalid  = rvalid_r;
    assign axil_rresp   = rresp_r;
    // Error reads and idle cycles present zero instead of stale array data
    assign axil_rdata   = (rvalid_r && (rresp_r == RESP_OKAY)) ? mem_rdata_s : '0;

endmodule

// File: tb/tb_adam_mem_axil.sv
// Self-checking bench for adam_mem_axil: directed scenarios plus randomized traffic
// checked against a byte-array reference model. Zero-init test runs when ADAM_MEM_ZERO_INIT_EN is defined.
module tb_adam_mem_axil;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk, rst_n, pause_req, pause_ack;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_m [4096];
    bit         last_write_m;

    adam_mem_axil #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SIZE(4096)) dut (
        .clk(clk), .rst_n(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
        .axil_awaddr(awaddr), .axil_awprot(awprot), .axil_awvalid(awvalid), .axil_awready(awready),
        .axil_wdata(wdata), .axil_wstrb(wstrb), .axil_wvalid(wvalid), .axil_wready(wready),
        .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready),
        .axil_araddr(araddr), .axil_arprot(arprot), .axil_arvalid(arvalid), .axil_arready(arready),
        .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: byte-addressed memory, SIZE bytes, out of range is SLVERR
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int base;
        if (a >= 32'd4096) return SLVERR;
        base = int'(a) & ~3;
        for (int b = 0; b < 4; b++) if (s[b]) mem_m[base + b] = d[8*b +: 8];
        return OKAY;
    endfunction

    function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int base;
        d = 32'h0;
        if (a >= 32'd4096) begin
            r = SLVERR;
        end else begin
            base = int'(a) & ~3;
            for (int b = 0; b < 4; b++) d[8*b +: 8] = mem_m[base + b];
            r = OKAY;
        end
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int bdelay,
                             output logic [1:0] resp, output logic lat, output logic to);
        int c;
        c = 0; to = 1'b0; resp = 2'b11; lat = 1'b0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        while (!(awready && wready) && c < 50) begin @(negedge clk); #1; c++; end
        if (c >= 50) begin
            to = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
        end else begin
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0;
            lat = bvalid; resp = bresp;
            repeat (bdelay) @(negedge clk);
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
        end
        last_write_m = 1'b1;
    endtask

    task automatic axi_read(input logic [31:0] a, input int rdelay, output logic [31:0] d, output logic [1:0] resp,
                            output logic lat, output logic [31:0] d_end, output logic v_end, output logic to);
        int c;
        c = 0; to = 1'b0; resp = 2'b11; lat = 1'b0; d = 32'hx; d_end = 32'hx; v_end = 1'b0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        #1;
        while (!arready && c < 50) begin @(negedge clk); #1; c++; end
        if (c >= 50) begin
            to = 1'b1; arvalid = 1'b0;
        end else begin
            @(negedge clk);
            arvalid = 1'b0;
            lat = rvalid; d = rdata; resp = rresp;
            repeat (rdelay) @(negedge clk);
            d_end = rdata; v_end = rvalid;
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
        last_write_m = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pause_req = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            n_tests++;
            if (pause_ack !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_handshake: ack=%b awr=%b wr=%b arr=%b, want ack=1 readys=0", pause_ack, awready, wready, arready);
            end
            n_tests++;
            if (bvalid !== 1'b0 || rvalid !== 1'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: bv=%b rv=%b bresp=%b rresp=%b rdata=%h, want all 0", bvalid, rvalid, bresp, rresp, rdata);
            end
        end
        @(negedge clk); rst_n = 1'b1;
`ifdef ADAM_MEM_ZERO_INIT_EN
        repeat (1030) @(negedge clk);
`endif
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (pause_ack !== 1'b1 || awready !== 1'b0 || arready !== 1'b0) begin
            n_fail++;
            $display("FAIL paused_readys: ack=%b awr=%b arr=%b, want ack=1 readys=0", pause_ack, awready, arready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        pause_req = 1'b0;
        #1;
        n_tests++;
        if (pause_ack !== 1'b1) begin
            n_fail++; $display("FAIL ack_before_fall: ack=%b want 1", pause_ack);
        end
        @(negedge clk); #1;
        n_tests++;
        if (pause_ack !== 1'b0) begin
            n_fail++; $display("FAIL ack_after_fall: ack=%b want 0", pause_ack);
        end
        @(negedge clk); pause_req = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (pause_ack !== 1'b1) begin
            n_fail++; $display("FAIL ack_rise_idle: ack=%b want 1", pause_ack);
        end
        pause_req = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (pause_ack !== 1'b0) begin
            n_fail++; $display("FAIL ack_refall: ack=%b want 0", pause_ack);
        end
        last_write_m = 1'b0;
    endtask

    task automatic test_strobe();
        logic [1:0] r, er; logic lat, to, v2; logic [31:0] d, d2, ed;
        er = model_write(32'h10, 32'hDEADBEEF, 4'hF);
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, r, lat, to);
        n_tests++;
        if (to || r !== er || lat !== 1'b1) begin
            n_fail++; $display("FAIL strobe_wr_full: to=%b bresp=%b lat=%b, want bresp=%b lat=1", to, r, lat, er);
        end
        er = model_write(32'h10, 32'h00AA0000, 4'h4);
        axi_write(32'h10, 32'h00AA0000, 4'h4, 1, r, lat, to);
        n_tests++;
        if (to || r !== er || lat !== 1'b1) begin
            n_fail++; $display("FAIL strobe_wr_byte: to=%b bresp=%b lat=%b, want bresp=%b lat=1", to, r, lat, er);
        end
        model_read(32'h10, ed, er);
        axi_read(32'h10, 0, d, r, lat, d2, v2, to);
        n_tests++;
        if (to || d !== ed || d !== 32'hDEAABEEF || r !== er || lat !== 1'b1) begin
            n_fail++; $display("FAIL strobe_readback: rdata=%h rresp=%b lat=%b, want rdata=%h rresp=%b lat=1", d, r, lat, ed, er);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r, er; logic lat, to, v2; logic [31:0] d, d2, ed;
        er = model_write(32'h0, 32'h11223344, 4'hF);
        axi_write(32'h0, 32'h11223344, 4'hF, 0, r, lat, to);
        er = model_write(32'h1000, 32'h12345678, 4'hF);
        axi_write(32'h1000, 32'h12345678, 4'hF, 0, r, lat, to);
        n_tests++;
        if (to || r !== er || r !== SLVERR) begin
            n_fail++; $display("FAIL oor_write: bresp=%b want %b", r, er);
        end
        model_read(32'h1000, ed, er);
        axi_read(32'h1000, 2, d, r, lat, d2, v2, to);
        n_tests++;
        if (to || d !== ed || r !== er || lat !== 1'b1 || d2 !== ed) begin
            n_fail++; $display("FAIL oor_read: rdata=%h rresp=%b, want rdata=%h rresp=%b", d, r, ed, er);
        end
        model_read(32'h0, ed, er);
        axi_read(32'h0, 0, d, r, lat, d2, v2, to);
        n_tests++;
        if (to || d !== ed || r !== er) begin
            n_fail++; $display("FAIL oor_alias: addr0 rdata=%h rresp=%b, want %h %b", d, r, ed, er);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] wa [2], wd [2], ed;
        logic [1:0] er;
        int wi, ri, c;
        bit exp_write, got_write;
        for (int i = 0; i < 2; i++) begin
            wa[i] = 32'($urandom_range(256, 1023)) << 2;
            wd[i] = $urandom;
        end
        wi = 0; ri = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            awvalid = (wi < 2); wvalid = (wi < 2); arvalid = (ri < 2);
            awaddr = wa[wi % 2]; wdata = wd[wi % 2]; wstrb = 4'hF; araddr = wa[ri % 2];
            bready = 1'b1; rready = (k == 1) ? 1'b0 : 1'b1;
            exp_write = (wi < 2) && ((ri >= 2) || !last_write_m);
            c = 0; #1;
            while (!awready && !arready && c < 20) begin @(negedge clk); #1; c++; end
            got_write = awready;
            n_tests++;
            if (c >= 20 || (awready && arready) || got_write != exp_write || awready !== wready) begin
                n_fail++;
                $display("FAIL sim_order[%0d]: awr=%b wr=%b arr=%b, want write=%b", k, awready, wready, arready, exp_write);
            end
            @(negedge clk);
            if (got_write) begin
                awvalid = 1'b0; wvalid = 1'b0;
                er = model_write(wa[wi % 2], wd[wi % 2], 4'hF);
                n_tests++;
                if (bvalid !== 1'b1 || bresp !== er || arready !== 1'b0) begin
                    n_fail++; $display("FAIL sim_bresp[%0d]: bv=%b bresp=%b arr=%b, want 1 %b 0", k, bvalid, bresp, arready, er);
                end
                last_write_m = 1'b1; wi++;
            end else begin
                arvalid = 1'b0;
                model_read(wa[ri % 2], ed, er);
                n_tests++;
                if (rvalid !== 1'b1 || rdata !== ed || rresp !== er) begin
                    n_fail++; $display("FAIL sim_rdata[%0d]: rv=%b rdata=%h rresp=%b, want 1 %h %b", k, rvalid, rdata, rresp, ed, er);
                end
                if (k == 1) begin
                    repeat (5) begin
                        @(negedge clk);
                        n_tests++;
                        if (rvalid !== 1'b1 || rdata !== ed || awready !== 1'b0) begin
                            n_fail++; $display("FAIL sim_hold: rv=%b rdata=%h awr=%b, want 1 %h 0", rvalid, rdata, awready, ed);
                        end
                    end
                    rready = 1'b1;
                end
                last_write_m = 1'b0; ri++;
            end
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    endtask

    task automatic test_pause();
        logic [31:0] a, d, ed; logic [1:0] er; int c;
        a = 32'($urandom_range(0, 1023)) << 2; d = $urandom;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        c = 0; #1;
        while (!awready && c < 20) begin @(negedge clk); #1; c++; end
        er = model_write(a, d, 4'hF);
        last_write_m = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; pause_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (pause_ack !== 1'b0 || bvalid !== 1'b1 || bresp !== er) begin
                n_fail++; $display("FAIL pause_in_bresp: ack=%b bv=%b bresp=%b, want 0 1 %b", pause_ack, bvalid, bresp, er);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        n_tests++;
        if (pause_ack !== 1'b1 || bvalid !== 1'b0) begin
            n_fail++; $display("FAIL pause_after_b: ack=%b bv=%b, want 1 0", pause_ack, bvalid);
        end
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        repeat (4) begin
            #1;
            n_tests++;
            if (arready !== 1'b0 || pause_ack !== 1'b1) begin
                n_fail++; $display("FAIL pause_no_ar: arr=%b ack=%b, want 0 1", arready, pause_ack);
            end
            @(negedge clk);
        end
        pause_req = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (pause_ack !== 1'b0 || arready !== 1'b1) begin
            n_fail++; $display("FAIL unpause_accept: ack=%b arr=%b, want 0 1", pause_ack, arready);
        end
        model_read(a, ed, er);
        @(negedge clk);
        arvalid = 1'b0;
        n_tests++;
        if (rvalid !== 1'b1 || rdata !== ed || rresp !== er) begin
            n_fail++; $display("FAIL pause_read: rv=%b rdata=%h rresp=%b, want 1 %h %b", rvalid, rdata, rresp, ed, er);
        end
        @(posedge clk); #1;
        last_write_m = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] words [16];
        logic [31:0] a, d, d2, ed; logic [1:0] r, er; logic lat, to, v2; logic [3:0] s;
        for (int i = 0; i < 16; i++) begin
            words[i] = 32'($urandom_range(64, 1023)) << 2;
            d = $urandom;
            er = model_write(words[i], d, 4'hF);
            axi_write(words[i], d, 4'hF, 0, r, lat, to);
        end
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h1000 + 32'($urandom_range(0, 4095));
                1:       a = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
                default: a = words[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                er = model_write(a, d, s);
                axi_write(a, d, s, $urandom_range(0, 3), r, lat, to);
                n_tests++;
                if (to || r !== er || lat !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_write[%0d]: a=%h to=%b bresp=%b lat=%b, want %b", n, a, to, r, lat, er);
                end
            end else begin
                model_read(a, ed, er);
                axi_read(a, $urandom_range(0, 3), d, r, lat, d2, v2, to);
                n_tests++;
                if (to || d !== ed || d2 !== ed || v2 !== 1'b1 || r !== er || lat !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_read[%0d]: a=%h rdata=%h/%h rresp=%b lat=%b, want %h %b", n, a, d, d2, r, lat, ed, er);
                end
            end
        end
    endtask

`ifdef ADAM_MEM_ZERO_INIT_EN
    task automatic test_zero_init();
        logic [1:0] r, er; logic lat, to, v2; logic [31:0] d, d2; int c;
        er = model_write(32'h20, 32'hFFFFFFFF, 4'hF);
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, r, lat, to);
        @(negedge clk); rst_n = 1'b0; pause_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; arvalid = 1'b1; araddr = 32'h20; rready = 1'b1;
        for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            pause_req = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk); #1;
            if (i % 128 == 0 || i == 1023) begin
                n_tests++;
                if (pause_ack !== 1'b1 || arready !== 1'b0) begin
                    n_fail++; $display("FAIL zinit_busy[%0d]: ack=%b arr=%b, want 1 0", i, pause_ack, arready);
                end
            end
        end
        arvalid = 1'b0;
        c = 0;
        while (pause_ack !== 1'b0 && c < 10) begin @(negedge clk); c++; end
        n_tests++;
        if (c >= 10) begin
            n_fail++; $display("FAIL zinit_unpause: ack=%b want 0 within 10 cycles", pause_ack);
        end
        last_write_m = 1'b0;
        axi_read(32'h20, 0, d, r, lat, d2, v2, to);
        n_tests++;
        if (to || d !== 32'h0 || r !== OKAY) begin
            n_fail++; $display("FAIL zinit_read: rdata=%h rresp=%b, want 0 00", d, r);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pause_req = 1'b1;
        awaddr = 32'h0; awprot = 3'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
        bready = 1'b0; araddr = 32'h0; arprot = 3'h0; arvalid = 1'b0; rready = 1'b0;
        last_write_m = 1'b0;
        test_reset();
        test_strobe();
        test_out_of_range();
        test_simultaneous();
        test_pause();
        test_random();
`ifdef ADAM_MEM_ZERO_INIT_EN
        test_zero_init();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
